uart_receiver: RTL and testbench

Receive half of the UART link: deserialises an 8N1 asynchronous stream on `rx` into bytes for the MIPS32 core's memory-mapped UART port. Samples `rx` using the 16x oversample tick from the UART baud-tick generator. Holds one received byte in a single-entry output buffer with a ready/read handshake, and reports framing and overrun errors.

---
 rtl/uart_receiver.sv | 149 ++++++++++++++
 tb/tb_uart_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
// Receive half of the UART link. Deserialises an 8N1 asynchronous stream on
// rx into bytes, sampling on the 16x oversample tick from the baud-tick
// generator. One received byte is held for the bus with a ready/read
// handshake, and framing and overrun errors are reported.
//
// Ports:
//   clock         system clock, all logic on posedge
//   reset         asynchronous active-high reset, clears all state
//   uart_tick_16  single-cycle oversample strobe
//   rx            serial line, idle high, asynchronous to clock
//   read          single-cycle consume strobe, clears data_ready and overrun
//   data          last received byte
//   data_ready    an unread byte is held in data
//   framing_error stop bit of the last completed frame was 0
//   overrun       a byte completed while the previous one was still unread
module uart_receiver #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 uart_tick_16,
   input  logic                 rx,
   input  logic                 read,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_ready,
   output logic                 framing_error,
   output logic                 overrun
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t               state_r;
   logic                 rx_meta_r;
   logic                 rx_sync_r;
   logic [TW-1:0]        tick_cnt_r;
   logic [BW-1:0]        bit_cnt_r;
   logic [DATA_BITS-1:0] shift_r;

   // Two-flop synchroniser; idle-high reset value avoids a false start bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Frame FSM, counters, shift register and registered bus-side outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         tick_cnt_r    <= '0;
         bit_cnt_r     <= '0;
         shift_r       <= '0;
         data          <= '0;
         data_ready    <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         // Bus consume; a completing frame below re-asserts data_ready.
         if (read && data_ready) begin
            data_ready <= 1'b0;
            overrun    <= 1'b0;
         end else begin
            data_ready <= data_ready;
         end

         if (uart_tick_16) begin
            case (state_r)
               IDLE: begin
                  if (!rx_sync_r) begin
                     state_r    <= START;
                     tick_cnt_r <= '0;
                  end else begin
                     state_r    <= IDLE;
                  end
               end
               START: begin
                  if (tick_cnt_r == HALF_LAST) begin
                     if (!rx_sync_r) begin
                        state_r    <= DATA;
                        tick_cnt_r <= '0;
                        bit_cnt_r  <= '0;
                     end else begin
                        // Line went high before mid start bit: a glitch.
                        state_r    <= IDLE;
                     end
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 1'b1;
                  end
               end
               DATA: begin
                  if (tick_cnt_r == FULL_LAST) begin
                     // LSB arrives first, so shift in at the top.
                     shift_r    <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
                     tick_cnt_r <= '0;
                     if (bit_cnt_r == BIT_LAST) begin
                        state_r <= STOP;
                     end else begin
                        bit_cnt_r <= bit_cnt_r + 1'b1;
                     end
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 1'b1;
                  end
               end
               STOP: begin
                  if (tick_cnt_r == FULL_LAST) begin
                     data          <= shift_r;
                     framing_error <= ~rx_sync_r;
                     data_ready    <= 1'b1;
                     if (data_ready && !read) begin
                        overrun <= 1'b1;
                     end else begin
                        overrun <= overrun & ~(read & data_ready);
                     end
                     // Leave mid stop bit so an immediate next start is seen.
                     tick_cnt_r    <= '0;
                     state_r       <= IDLE;
                  end else begin
                     tick_cnt_r <= tick_cnt_r + 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end else begin
            state_r <= state_r;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       uart_tick_16 = 1'b0;
   logic       rx = 1'b1;
   logic       read = 1'b0;
   logic [7:0] data;
   logic       data_ready;
   logic       framing_error;
   logic       overrun;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
   } exp_t;

   exp_t exp_q[$];

   uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clock        (clock),
      .reset        (reset),
      .uart_tick_16 (uart_tick_16),
      .rx           (rx),
      .read         (read),
      .data         (data),
      .data_ready   (data_ready),
      .framing_error(framing_error),
      .overrun      (overrun)
   );

   // 100 MHz-style clock, period 10
   initial begin
      forever #5 clock = ~clock;
   end

   // Oversample tick every 4 clocks, driven on the falling edge
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clock);
         uart_tick_16 = (c == 3);
         c = (c + 1) % 4;
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clock); while (uart_tick_16 !== 1'b1);
      end
   endtask

   task automatic set_rx(input logic v);
      @(negedge clock);
      rx = v;
   endtask

   task automatic idle(input int n);
      set_rx(1'b1);
      wait_ticks(n);
   endtask

   task automatic do_read();
      @(negedge clock);
      read = 1'b1;
      @(negedge clock);
      read = 1'b0;
      #1;
   endtask

   // Sends one frame (16 ticks per bit) and leaves the stop level on rx.
   // With rd_at_done, read is pulsed on the stop-sample tick's clock edge.
   task automatic send_byte(input logic [7:0] b, input logic stop, input logic rd_at_done);
      exp_q.push_back({b, ~stop});
      set_rx(1'b0);
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         set_rx(b[i]);
         wait_ticks(16);
      end
      set_rx(stop);
      if (rd_at_done) begin
         wait_ticks(8);
         do begin
            @(negedge clock);
            #1;
         end while (uart_tick_16 !== 1'b1);
         read = 1'b1;
         @(negedge clock);
         read = 1'b0;
         wait_ticks(7);
      end else begin
         wait_ticks(16);
      end
   endtask

   // Monitor: a delivery is data_ready rising, or data changing while ready
   initial begin
      logic       pr;
      logic [7:0] pd;
      exp_t       e;
      pr = 1'b0;
      pd = 8'h00;
      forever begin
         @(negedge clock);
         if (data_ready === 1'b1 && (pr !== 1'b1 || data !== pd)) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %0h expected none", data);
            end else begin
               e = exp_q.pop_front();
               check("rx_data", {24'h0, data}, {24'h0, e.d});
               check("rx_fe", {31'h0, framing_error}, {31'h0, e.fe});
            end
         end
         pr = data_ready;
         pd = data;
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clock);
      #1;
      check("rst_data", {24'h0, data}, 32'h0);
      check("rst_ready", {31'h0, data_ready}, 32'h0);
      check("rst_fe", {31'h0, framing_error}, 32'h0);
      check("rst_ovr", {31'h0, overrun}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      idle(4);

      // Basic byte
      send_byte(8'h55, 1'b1, 1'b0);
      idle(4);
      check("basic_ready", {31'h0, data_ready}, 32'h1);
      check("basic_fe", {31'h0, framing_error}, 32'h0);
      do_read();
      check("basic_ready_after_read", {31'h0, data_ready}, 32'h0);
      check("basic_ovr", {31'h0, overrun}, 32'h0);

      // Glitch reject
      set_rx(1'b0);
      wait_ticks(3);
      idle(24);
      check("glitch_ready", {31'h0, data_ready}, 32'h0);

      // Framing error, then a good frame clears it
      send_byte(8'h3C, 1'b0, 1'b0);
      idle(24);
      check("fe_set", {31'h0, framing_error}, 32'h1);
      check("fe_ready", {31'h0, data_ready}, 32'h1);
      do_read();
      send_byte(8'h81, 1'b1, 1'b0);
      idle(4);
      check("fe_cleared", {31'h0, framing_error}, 32'h0);
      do_read();

      // Overrun
      send_byte(8'h11, 1'b1, 1'b0);
      idle(4);
      send_byte(8'h22, 1'b1, 1'b0);
      idle(4);
      check("ovr_data", {24'h0, data}, 32'h22);
      check("ovr_set", {31'h0, overrun}, 32'h1);
      do_read();
      check("ovr_ready_cleared", {31'h0, data_ready}, 32'h0);
      check("ovr_cleared", {31'h0, overrun}, 32'h0);

      // Read coincident with completion of the second byte
      send_byte(8'h3A, 1'b1, 1'b0);
      send_byte(8'h7E, 1'b1, 1'b1);
      idle(4);
      check("sim_data", {24'h0, data}, 32'h7E);
      check("sim_ready", {31'h0, data_ready}, 32'h1);
      check("sim_ovr", {31'h0, overrun}, 32'h0);
      do_read();

      // Back-to-back frames with zero idle gap
      send_byte(8'hC3, 1'b1, 1'b0);
      send_byte(8'h0F, 1'b1, 1'b0);
      send_byte(8'hE7, 1'b1, 1'b0);
      idle(4);
      check("b2b_data", {24'h0, data}, 32'hE7);
      check("b2b_ovr", {31'h0, overrun}, 32'h1);
      do_read();

      // Reset mid-frame with an unread byte held
      send_byte(8'hF0, 1'b1, 1'b0);
      idle(4);
      check("pre_rst_ready", {31'h0, data_ready}, 32'h1);
      set_rx(1'b0);
      wait_ticks(16);
      set_rx(1'b1);
      set_rx(1'b0);
      wait_ticks(30);
      @(negedge clock);
      reset = 1'b1;
      rx = 1'b1;
      #1;
      check("midrst_data", {24'h0, data}, 32'h0);
      check("midrst_ready", {31'h0, data_ready}, 32'h0);
      check("midrst_fe", {31'h0, framing_error}, 32'h0);
      check("midrst_ovr", {31'h0, overrun}, 32'h0);
      repeat (5) @(negedge clock);
      reset = 1'b0;
      idle(8);
      send_byte(8'hA5, 1'b1, 1'b0);
      idle(4);
      check("post_rst_data", {24'h0, data}, 32'hA5);
      check("post_rst_ready", {31'h0, data_ready}, 32'h1);
      do_read();

      idle(10);
      check("queue_empty", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
